// File: rtl/fusion_pkg.sv
// -----------------------------------------------------------------------------
// fusion_pkg
// Shared definitions for the fetch front end: reset defaults, the fetch FSM
// state encoding, the instruction-buffer entry layout and small address
// helpers. No ports; imported by fetch_fifo and fetch_32.
// -----------------------------------------------------------------------------
package fusion_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN_DEFAULT     = 32'h0000_0000;

  // RUN: free to issue; WAIT: one request outstanding;
  // DROP: the outstanding response belongs to a squashed path.
  typedef enum logic [1:0] {
    FETCH_RUN  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small circular buffer of {insn, pc} entries between fetch and decode.
//   clk, rst          : clock, asynchronous active-high reset
//   push_i, wdata_i   : write an entry at the tail (ignored when full)
//   pop_i             : drop the head entry (ignored when empty)
//   flush_i           : discard all entries; wins over push and pop
//   rdata_o           : head entry (meaningful only when !empty_o)
//   full_o, empty_o   : occupancy flags
//   count_o           : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fusion_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: state registers take the asynchronous reset and use non-blocking
  // assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_32.sv
// -----------------------------------------------------------------------------
// fetch_32
// Instruction fetch stage: keeps the fetch PC, issues one request at a time
// to instruction memory, buffers returned words and hands them to decode.
//   clk_in, reset_in          : clock, asynchronous active-high reset
//   stall_in                  : decode cannot take insn_out this cycle
//   redirect_in/_pc_in        : flush and restart fetch at a new address
//   imem_req_out/_addr_out    : memory request (accepted the cycle it is high)
//   imem_ack_in/_data_in      : memory response, one per request
//   insn_out/_pc_out/_valid_out : buffer head presented to decode
//   misalign_flg_out          : one-cycle pulse for a redirect target with
//                               nonzero low bits
// -----------------------------------------------------------------------------
module fetch_32
  import fusion_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          BUF_DEPTH    = 2,
  parameter logic [31:0] NOP_INSN     = NOP_INSN_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] insn_out,
  output logic [31:0] insn_pc_out,
  output logic        insn_valid_out,
  output logic        misalign_flg_out
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      req_addr_q;
  logic             misalign_q;

  logic             issue, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head, push_entry;

  // Issuing only below full occupancy, with a single request in flight,
  // guarantees a free slot when the response lands. reset_in is folded in
  // so the request drops asynchronously with reset.
  assign imem_req_out  = !reset_in && (state_q == FETCH_RUN) &&
                         (fifo_count < CNT_W'(BUF_DEPTH)) && !redirect_in;
  assign imem_addr_out = pc_q;
  assign issue         = imem_req_out;

  // Responses are kept only in WAIT; a same-edge redirect squashes them.
  assign push       = imem_ack_in && (state_q == FETCH_WAIT) && !redirect_in && !fifo_full;
  assign pop        = !fifo_empty && !stall_in;
  assign push_entry = '{insn: imem_data_in, pc: req_addr_q};

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk_in),
    .rst     (reset_in),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_in),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign insn_valid_out   = !fifo_empty;
  assign insn_out         = fifo_empty ? NOP_INSN : head.insn;
  assign insn_pc_out      = fifo_empty ? 32'h0 : head.pc;
  assign misalign_flg_out = misalign_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_VECTOR;
      req_addr_q <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_in && is_misaligned(redirect_pc_in);

      // Redirect wins over sequential advance; +4 wraps at the top of memory.
      if (redirect_in)  pc_q <= word_align(redirect_pc_in);
      else if (issue)   pc_q <= pc_q + 32'd4;

      if (issue) req_addr_q <= pc_q;

      case (state_q)
        FETCH_RUN:  if (issue) state_q <= FETCH_WAIT;
        FETCH_WAIT: begin
          if (imem_ack_in)      state_q <= FETCH_RUN;
          else if (redirect_in) state_q <= FETCH_DROP;
        end
        FETCH_DROP: if (imem_ack_in) state_q <= FETCH_RUN;
        default:    state_q <= FETCH_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_32.sv
// -----------------------------------------------------------------------------
// tb_fetch_32
// Drives fetch_32 with a behavioural instruction memory of configurable
// latency. Returned words are queued on acceptance and compared against the
// DUT's presented head every cycle.
// -----------------------------------------------------------------------------
module tb_fetch_32;
  import fusion_pkg::*;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RST_VEC   = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        reset_in, stall_in, redirect_in, imem_ack_in;
  logic [31:0] redirect_pc_in, imem_data_in;
  logic        imem_req_out, insn_valid_out, misalign_flg_out;
  logic [31:0] imem_addr_out, insn_out, insn_pc_out;

  fetch_32 #(.RESET_VECTOR(RST_VEC), .BUF_DEPTH(BUF_DEPTH), .NOP_INSN(NOP)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .stall_in         (stall_in),
    .redirect_in      (redirect_in),
    .redirect_pc_in   (redirect_pc_in),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_ack_in      (imem_ack_in),
    .imem_data_in     (imem_data_in),
    .insn_out         (insn_out),
    .insn_pc_out      (insn_pc_out),
    .insn_valid_out   (insn_valid_out),
    .misalign_flg_out (misalign_flg_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Scoreboard and memory model state
  fetch_entry_t sb_q[$];
  logic [31:0]  issued_q[$];
  logic [31:0]  delivered_q[$];
  bit           mem_pending, mem_stale;
  logic [31:0]  mem_addr, mem_xor;
  int           mem_wait, mem_lat;
  logic [31:0]  model_pc;
  bit           exp_mis;
  logic         last_valid, last_req, last_mis;
  logic [31:0]  last_pc;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
    logic        exp_mis;
  } redir_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare just after, update models at posedge.
  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc);
    bit          ack, exp_req, got_req;
    logic [31:0] got_addr, ack_data;
    @(negedge clk_in);
    stall_in       = stall;
    redirect_in    = redir;
    redirect_pc_in = rpc;
    ack            = mem_pending && (mem_wait == 0);
    ack_data       = mem_addr ^ mem_xor;
    imem_ack_in    = ack;
    imem_data_in   = ack ? ack_data : 32'hDEAD_BEEF;
    #1;
    exp_req = !mem_pending && (sb_q.size() < BUF_DEPTH) && !redir;
    check("imem_req", 32'(imem_req_out), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr_out, model_pc);
    check("insn_valid", 32'(insn_valid_out), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      check("insn_pc", insn_pc_out, sb_q[0].pc);
      check("insn", insn_out, sb_q[0].insn);
    end else begin
      check("nop_insn", insn_out, NOP);
      check("nop_pc", insn_pc_out, 32'h0);
    end
    check("misalign", 32'(misalign_flg_out), 32'(exp_mis));
    last_valid = insn_valid_out;
    last_pc    = insn_pc_out;
    last_req   = imem_req_out;
    last_mis   = misalign_flg_out;
    got_req    = imem_req_out;
    got_addr   = imem_addr_out;
    if (insn_valid_out && !stall && !redir) delivered_q.push_back(insn_pc_out);
    @(posedge clk_in);
    if (redir) sb_q.delete();
    else begin
      if (sb_q.size() != 0 && !stall) sb_q.delete(0);
      if (ack && !mem_stale) sb_q.push_back('{insn: ack_data, pc: mem_addr});
    end
    if (ack) begin
      mem_pending = 1'b0;
      mem_stale   = 1'b0;
    end else if (mem_pending && mem_wait > 0) mem_wait--;
    if (redir && mem_pending) mem_stale = 1'b1;
    if (got_req) begin
      mem_pending = 1'b1;
      mem_stale   = 1'b0;
      mem_addr    = got_addr;
      mem_wait    = mem_lat - 1;
      issued_q.push_back(got_addr);
    end
    if (redir)        model_pc = {rpc[31:2], 2'b00};
    else if (exp_req) model_pc = model_pc + 32'd4;
    exp_mis = redir && (rpc[1:0] != 2'b00);
  endtask

  task automatic wait_issue(input int n, input string name);
    int k = 0;
    while (issued_q.size() <= n && k < 30) begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end
    check({name, "_timeout"}, 32'(issued_q.size() > n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(imem_req_out), 32'd0);
    check({tag, "_valid"}, 32'(insn_valid_out), 32'd0);
    check({tag, "_insn"}, insn_out, NOP);
    check({tag, "_pc"}, insn_pc_out, 32'h0);
    check({tag, "_mis"}, 32'(misalign_flg_out), 32'd0);
  endtask

  initial begin
    redir_vec_t  tbl[5];
    int          n, k;
    logic [31:0] frozen;

    tbl[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 1'b1};
    tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    tbl[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    tbl[3] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 1'b0};
    tbl[4] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004, 1'b1};

    reset_in = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = 32'h0;
    imem_ack_in = 1'b0; imem_data_in = 32'h0;
    mem_pending = 1'b0; mem_stale = 1'b0; mem_addr = 32'h0; mem_wait = 0;
    mem_lat = 1; mem_xor = 32'h0; model_pc = RST_VEC; exp_mis = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_in);
    #1 check_reset_outputs("reset");
    @(posedge clk_in);
    #2 reset_in = 1'b0;

    // In-order stream, word = address
    repeat (8) step(1'b0, 1'b0, 32'h0);
    if (issued_q.size() >= 3) begin
      check("stream_req0", issued_q[0], RST_VEC);
      check("stream_req1", issued_q[1], 32'h4);
      check("stream_req2", issued_q[2], 32'h8);
    end else check("stream_req_count", issued_q.size(), 32'd3);
    if (delivered_q.size() >= 2) begin
      check("stream_out0", delivered_q[0], 32'h0);
      check("stream_out1", delivered_q[1], 32'h4);
    end else check("stream_out_count", delivered_q.size(), 32'd2);

    // Stall for 5 cycles: buffer fills, requests stop, head frozen
    mem_xor = 32'hA5A5_0000;
    delivered_q.delete();
    step(1'b1, 1'b0, 32'h0);
    frozen = last_pc;
    repeat (4) begin
      step(1'b1, 1'b0, 32'h0);
      check("stall_hold_pc", last_pc, frozen);
    end
    check("stall_full_valid", 32'(last_valid), 32'd1);
    check("stall_full_noreq", 32'(last_req), 32'd0);
    repeat (10) step(1'b0, 1'b0, 32'h0);
    if (delivered_q.size() >= 3) begin
      check("stall_release_head", delivered_q[0], frozen);
      for (int i = 0; i + 1 < delivered_q.size(); i++)
        check("stall_release_seq", delivered_q[i+1], delivered_q[i] + 32'd4);
    end else check("stall_release_count", delivered_q.size(), 32'd3);

    // Redirect while a request is outstanding: late ack discarded
    mem_lat = 3;
    k = 0;
    while (!(mem_pending && mem_wait == 2) && k < 10) begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end
    check("wait_reached", 32'(mem_pending && mem_wait == 2), 32'd1);
    n = issued_q.size();
    step(1'b0, 1'b1, 32'h0000_0100);
    delivered_q.delete();
    wait_issue(n, "redir_wait");
    if (issued_q.size() > n) check("redir_wait_req", issued_q[n], 32'h0000_0100);
    k = 0;
    while (delivered_q.size() == 0 && k < 20) begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end
    if (delivered_q.size() != 0) check("redir_wait_first", delivered_q[0], 32'h0000_0100);
    else check("redir_wait_first_timeout", 32'd0, 32'd1);

    // Redirect coinciding with the ack: data dropped, buffer empty
    mem_lat = 1;
    k = 0;
    while (!(mem_pending && mem_wait == 0) && k < 10) begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end
    n = issued_q.size();
    step(1'b0, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b0, 32'h0);
    check("redir_ack_empty", 32'(last_valid), 32'd0);
    check("redir_ack_req", 32'(last_req), 32'd1);
    if (issued_q.size() > n) check("redir_ack_addr", issued_q[n], 32'h0000_0200);
    else check("redir_ack_issue", issued_q.size(), n + 1);

    // Redirect table: alignment, misalign pulse, wrap at top of memory
    foreach (tbl[i]) begin
      n = issued_q.size();
      step(1'b0, 1'b1, tbl[i].target);
      step(1'b0, 1'b0, 32'h0);
      check("tbl_mis", 32'(last_mis), 32'(tbl[i].exp_mis));
      wait_issue(n + 1, "tbl_issue");
      if (issued_q.size() > n + 1) begin
        check("tbl_first", issued_q[n], tbl[i].exp_first);
        check("tbl_second", issued_q[n+1], tbl[i].exp_second);
      end
    end

    // Reset mid-operation: WAIT with one buffered entry
    step(1'b0, 1'b1, 32'h0000_0300);
    mem_lat = 4;
    k = 0;
    while (!(sb_q.size() == 1 && mem_pending) && k < 20) begin
      step(1'b1, 1'b0, 32'h0);
      k++;
    end
    check("midrst_setup", 32'(sb_q.size() == 1 && mem_pending), 32'd1);
    check("midrst_pre_valid", 32'(insn_valid_out), 32'd1);
    @(negedge clk_in);
    #2;
    reset_in = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; imem_ack_in = 1'b0;
    #1 check_reset_outputs("midrst");
    sb_q.delete();
    mem_pending = 1'b0; mem_stale = 1'b0; model_pc = RST_VEC; exp_mis = 1'b0;
    mem_lat = 1;
    n = issued_q.size();
    repeat (2) @(posedge clk_in);
    #2 reset_in = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    if (issued_q.size() > n) check("midrst_first_req", issued_q[n], RST_VEC);
    else check("midrst_first_issue", issued_q.size(), n + 1);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_32.md
FETCH_32 -- requirements
Module: fetch_32

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries, power of two, minimum 2.
REQ-003 SHALL have parameter NOP_INSN, default 32'h0000_0000: word driven on insn_out when no instruction is valid.
REQ-004 SHALL have port clk_in  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_in  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port stall_in  input  1: decode cannot accept this cycle.
REQ-007 SHALL have port redirect_in  input  1: PC change request (taken branch/jump/syscall).
REQ-008 SHALL have port redirect_pc_in  input  32: redirect target address.
REQ-009 SHALL have port imem_req_out  output  1: instruction memory request valid.
REQ-010 SHALL have port imem_addr_out  output  32: request word address.
REQ-011 SHALL have port imem_ack_in  input  1: response valid; at most one per request.
REQ-012 SHALL have port imem_data_in  input  32: response instruction word.
REQ-013 SHALL have port insn_out  output  32: instruction to decode.
REQ-014 SHALL have port insn_pc_out  output  32: address of insn_out.
REQ-015 SHALL have port insn_valid_out  output  1: insn_out and insn_pc_out are a real instruction.
REQ-016 SHALL have port misalign_flg_out  output  1: one-cycle pulse when a redirect target has bits [1:0] nonzero.

Function
REQ-017 SHALL keep a fetch PC. A request is accepted when imem_req_out=1 and the FSM is in RUN. After acceptance, PC advances by 4 and wraps from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-018 SHALL allow at most one outstanding memory request.
REQ-019 SHALL use FSM states RUN (free to issue), WAIT (request outstanding) and DROP (outstanding response must be discarded).
REQ-020 SHALL have the following FSM transitions:
- RUN->WAIT on issue.
- WAIT->RUN on imem_ack_in.
- WAIT->DROP on redirect_in without ack.
- DROP->RUN on imem_ack_in, with the data discarded.
REQ-021 SHALL assert imem_req_out only in RUN, only when occupancy < BUF_DEPTH, and only when redirect_in=0.
REQ-022 SHALL drive imem_addr_out = PC, held stable while imem_req_out=1.
REQ-023 SHALL, on imem_ack_in in WAIT without redirect, write {imem_data_in, request address} into the buffer in the same edge.
REQ-024 SHALL present the buffer head on insn_out/insn_pc_out with insn_valid_out=1 whenever the buffer is not empty.
REQ-025 SHALL present NOP_INSN, pc 32'h0 and insn_valid_out=0 when the buffer is empty.
REQ-026 SHALL pop the head on an edge where insn_valid_out=1 and stall_in=0. Under stall_in=1 all outputs hold.
REQ-027 SHALL allow push and pop on the same edge; occupancy is then unchanged.
REQ-028 SHALL never overflow the buffer: issue is gated so the buffer cannot be full when a response returns.
REQ-029 SHALL, on redirect_in=1, on that edge:
- flush the buffer (occupancy 0);
- load PC = {redirect_pc_in[31:2], 2'b00};
- pulse misalign_flg_out if redirect_pc_in[1:0] != 0.
REQ-030 SHALL, when redirect_in and imem_ack_in occur together, discard the response and go to RUN.
REQ-031 SHALL give redirect priority over stall_in: a flush occurs even while stalled.
REQ-032 SHALL have latency redirect edge -> first imem_req_out of 1 cycle, and ack edge -> insn_valid_out of 1 cycle (registered output).

Reset
REQ-033 SHALL, while reset_in=1, asynchronously set:
- PC = RESET_VECTOR, FSM = RUN, occupancy 0;
- imem_req_out=0, insn_valid_out=0, insn_out=NOP_INSN, insn_pc_out=0, misalign_flg_out=0.
REQ-034 SHALL ignore a response arriving after reset deasserts for a request issued before reset; the memory side is also reset.
REQ-035 SHALL issue the first request to RESET_VECTOR on the first edge after reset deasserts.

Structure
REQ-036 SHALL take RESET_VECTOR default, NOP_INSN and the fetch state enumeration from the shared package fusion_pkg.
REQ-037 SHALL implement the buffer as the sub-module fetch_fifo:
- storage of {insn, pc} entries;
- push, pop and flush ports;
- full, empty and count outputs.

Verification
REQ-038 SHALL cover reset and the in-order stream: release reset, 1-cycle ack memory returning word = address -> requests to 0x0, 0x4, 0x8, and insn_out/insn_pc_out pairs (0x0,0x0), (0x4,0x4) in order, with no gaps.
REQ-039 SHALL cover stall and buffer full: hold stall_in=1 for 5 cycles -> occupancy reaches 2, imem_req_out drops to 0, outputs frozen; on release there is no lost or duplicated PC.
REQ-040 SHALL cover redirect with a request outstanding: redirect to 0x100 while WAIT -> late ack discarded, next request 0x100, first valid insn_pc_out = 0x100.
REQ-041 SHALL cover redirect and ack on the same edge: redirect to 0x200 with ack -> data dropped, buffer empty, next request 0x200.
REQ-042 SHALL cover misaligned redirect and wrap: redirect to 0x103 -> misalign pulse 1 cycle, request 0x100; redirect to 0xFFFF_FFFC -> next request 0x0000_0000.
REQ-043 SHALL cover reset mid-operation: assert reset_in during WAIT with buffer occupancy 1 -> outputs reach their reset values immediately (asynchronous), and after release the first request is RESET_VECTOR.
